bsg_manycore_vcache_dma_arbiter: RTL and testbench
==================================================

BSG_MANYCORE_VCACHE_DMA_ARBITER -- requirements
Module: bsg_manycore_vcache_dma_arbiter

Interface
REQ-001 SHALL have parameter num_caches_p, default "inv": number of non-blocking vcaches sharing one DMA channel, at least 2.
REQ-002 SHALL have parameter data_width_p, default "inv": DMA data word width.
REQ-003 SHALL have parameter dma_pkt_width_p, default "inv": DMA packet width; MSB is write_not_read, remaining bits are the address.
REQ-004 SHALL have parameter block_size_in_words_p, default "inv": words per fill or evict burst.
REQ-005 SHALL have parameter order_fifo_els_p, default 4: depth of each outstanding-burst order FIFO.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port dma_pkt_i, input, num_caches_p*dma_pkt_width_p: per-cache packets.
REQ-009 SHALL have port dma_pkt_v_i, input, num_caches_p: per-cache packet valid.
REQ-010 SHALL have port dma_pkt_yumi_o, output, num_caches_p: per-cache packet accept.
REQ-011 SHALL have port dma_data_o, output, data_width_p: fill data broadcast to all caches.
REQ-012 SHALL have port dma_data_v_o, output, num_caches_p: per-cache fill valid.
REQ-013 SHALL have port dma_data_ready_i, input, num_caches_p: per-cache fill ready.
REQ-014 SHALL have port dma_data_i, input, num_caches_p*data_width_p: per-cache evict data.
REQ-015 SHALL have port dma_data_v_i, input, num_caches_p: per-cache evict valid.
REQ-016 SHALL have port dma_data_yumi_o, output, num_caches_p: per-cache evict accept.
REQ-017 SHALL have ports mem_pkt_o/mem_pkt_v_o (outputs) and mem_pkt_yumi_i (input): the shared downstream packet channel.
REQ-018 SHALL have ports mem_data_i/mem_data_v_i (inputs) and mem_data_ready_o (output): the shared downstream fill channel.
REQ-019 SHALL have ports mem_data_o/mem_data_v_o (outputs) and mem_data_yumi_i (input): the shared downstream evict channel.

Function
REQ-020 SHALL select one cache per cycle round-robin among eligible requesters; a requester is eligible when its valid is high and the order FIFO matching its packet type is not full.
REQ-021 SHALL combinationally drive mem_pkt_o and mem_pkt_v_o from the selected cache, with zero-cycle latency.
REQ-022 SHALL assert dma_pkt_yumi_o[sel] only when mem_pkt_yumi_i is high, with all other yumi bits low.
REQ-023 SHALL hold the round-robin pointer while mem_pkt_yumi_i is low; on accept, the pointer SHALL move to sel+1 modulo num_caches_p.
REQ-024 On accepting a read packet, SHALL push the cache id into read_fifo; on accepting a write packet, SHALL push it into write_fifo.
REQ-025 A full FIFO SHALL block pushes even when a pop occurs in the same cycle.
REQ-026 Fill routing: dma_data_v_o[head] = mem_data_v_i AND read_fifo non-empty; all other bits SHALL be 0.
REQ-027 mem_data_ready_o SHALL equal read_fifo non-empty AND dma_data_ready_i[head].
REQ-028 Fill beat counter SHALL increment on each v&ready beat; on beat block_size_in_words_p-1 it SHALL wrap to 0 and pop read_fifo.
REQ-029 Evict routing: mem_data_o = dma_data_i[wr_head], and mem_data_v_o = write_fifo non-empty AND dma_data_v_i[wr_head].
REQ-030 dma_data_yumi_o[wr_head] SHALL equal mem_data_yumi_i; all other bits SHALL be 0.
REQ-031 Evict beat counter SHALL increment on each yumi beat; on the last beat it SHALL wrap to 0 and pop write_fifo.
REQ-032 Fill and evict channels SHALL be independent and may transfer in the same cycle.
REQ-033 Packet accept and burst completion SHALL proceed in the same cycle when both occur.
REQ-034 mem_data_v_i arriving with read_fifo empty SHALL not be acked, since mem_data_ready_o=0.
REQ-035 Counter widths SHALL be clog2(block_size_in_words_p); id width SHALL be clog2(num_caches_p), safe-clog2 for degenerate values.

Reset
REQ-036 reset_n_i low SHALL asynchronously clear both FIFOs to empty, both beat counters to 0, and the round-robin pointer to 0.
REQ-037 During reset, all valid, yumi and ready outputs SHALL be 0.
REQ-038 Reset asserted mid-burst SHALL discard in-flight order state; downstream is reset together.

Structure
REQ-039 Shared package bsg_manycore_vcache_dma_arb_pkg SHALL hold the write_not_read bit position and the id-width function.
REQ-040 Sub-module bsg_manycore_vcache_dma_order_fifo (async-low-reset small FIFO of ids) SHALL be instantiated twice.

Verification (num_caches_p=4, block=8, fifo=4)
REQ-041 Caches 0-3 all issue reads at once, yumi held high -> grants in order 0,1,2,3; read_fifo holds 0,1,2,3.
REQ-042 8 fill beats after REQ-041 -> only dma_data_v_o[0] asserts; read_fifo pops after beat 7; the next beat goes to cache 1.
REQ-043 5 reads back-to-back with no fill returns -> 4 accepted, 5th stalled; a write from cache 2 is still granted.
REQ-044 dma_data_ready_i[0]=0 during a fill -> mem_data_ready_o=0; counter holds until ready returns.
REQ-045 Evict from cache 3 with mem_data_yumi_i toggling -> 8 words forwarded in order; write_fifo pops on the 8th yumi.
REQ-046 reset_n_i pulsed at fill beat 3 -> outputs 0 immediately; FIFOs empty and counters 0 after release.

Source files
------------

// File: rtl/bsg_manycore_vcache_dma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bsg_manycore_vcache_dma_arb_pkg
// Purpose  : Shared helpers for the vcache DMA arbiter: DMA packet field
//            position and a clog2 that stays at least 1 bit wide.
// Revision : 1.0 - initial release
// ============================================================================
package bsg_manycore_vcache_dma_arb_pkg;

    // clog2 that never collapses to a zero-width vector for n <= 1.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The write_not_read flag sits in the MSB of a DMA packet.
    function automatic int wnr_bit(input int pkt_width);
        return pkt_width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_vcache_dma_order_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_vcache_dma_order_fifo
// Purpose  : Small FIFO of cache ids recording the order in which bursts were
//            issued downstream. A push while full is dropped even when a pop
//            happens in the same cycle; callers only push when not full.
// Ports    : i_clk, i_rst_n (async active-low), i_push/i_id, i_pop,
//            o_head (oldest id), o_empty, o_full
// Revision : 1.0 - initial release
// ============================================================================
module bsg_manycore_vcache_dma_order_fifo
    import bsg_manycore_vcache_dma_arb_pkg::*;
#(
    parameter int ELS      = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_push,
    input  logic [ID_WIDTH-1:0] i_id,
    input  logic                i_pop,
    output logic [ID_WIDTH-1:0] o_head,
    output logic                o_empty,
    output logic                o_full
);

    localparam int c_PTR_W = safe_clog2(ELS);
    localparam int c_CNT_W = $clog2(ELS + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(ELS - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(ELS);

    logic [ID_WIDTH-1:0] r_mem [ELS];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_push;
    logic                w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL_CNT);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_vcache_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_vcache_dma_arbiter
// Purpose  : Shares one DMA channel among num_caches_p non-blocking vcaches.
//            Packets are granted round-robin; the id of every accepted burst
//            is queued (reads and writes separately) so that returning fill
//            data and outgoing evict data are steered to/from the right cache.
// Ports    : clk_i, reset_n_i (async active-low)
//            dma_pkt_i/_v_i/_yumi_o      per-cache request packets
//            dma_data_o/_v_o/_ready_i    fill data to caches
//            dma_data_i/_v_i/_yumi_o     evict data from caches
//            mem_pkt_o/_v_o/_yumi_i      shared downstream packet channel
//            mem_data_i/_v_i/_ready_o    shared downstream fill channel
//            mem_data_o/_v_o/_yumi_i     shared downstream evict channel
// Revision : 1.0 - initial release
// ============================================================================
module bsg_manycore_vcache_dma_arbiter
    import bsg_manycore_vcache_dma_arb_pkg::*;
#(
    parameter int num_caches_p          = 4,
    parameter int data_width_p          = 32,
    parameter int dma_pkt_width_p       = 32,
    parameter int block_size_in_words_p = 8,
    parameter int order_fifo_els_p      = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,

    input  logic [num_caches_p*dma_pkt_width_p-1:0] dma_pkt_i,
    input  logic [num_caches_p-1:0]               dma_pkt_v_i,
    output logic [num_caches_p-1:0]               dma_pkt_yumi_o,

    output logic [data_width_p-1:0]               dma_data_o,
    output logic [num_caches_p-1:0]               dma_data_v_o,
    input  logic [num_caches_p-1:0]               dma_data_ready_i,

    input  logic [num_caches_p*data_width_p-1:0]  dma_data_i,
    input  logic [num_caches_p-1:0]               dma_data_v_i,
    output logic [num_caches_p-1:0]               dma_data_yumi_o,

    output logic [dma_pkt_width_p-1:0]            mem_pkt_o,
    output logic                                  mem_pkt_v_o,
    input  logic                                  mem_pkt_yumi_i,

    input  logic [data_width_p-1:0]               mem_data_i,
    input  logic                                  mem_data_v_i,
    output logic                                  mem_data_ready_o,

    output logic [data_width_p-1:0]               mem_data_o,
    output logic                                  mem_data_v_o,
    input  logic                                  mem_data_yumi_i
);

    localparam int c_ID_W  = safe_clog2(num_caches_p);
    localparam int c_CNT_W = safe_clog2(block_size_in_words_p);
    localparam int c_WNR   = wnr_bit(dma_pkt_width_p);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(block_size_in_words_p - 1);
    localparam logic [c_ID_W-1:0]  c_LAST_ID   = c_ID_W'(num_caches_p - 1);

    logic [dma_pkt_width_p-1:0] w_pkt      [num_caches_p];
    logic [data_width_p-1:0]    w_evict    [num_caches_p];
    logic [num_caches_p-1:0]    w_elig;

    logic [c_ID_W-1:0]  r_rr_ptr;
    logic [c_ID_W-1:0]  w_sel;
    logic               w_any;
    logic               w_accept;
    logic               w_sel_wnr;

    logic [c_ID_W-1:0]  w_rd_head;
    logic               w_rd_empty;
    logic               w_rd_full;
    logic [c_ID_W-1:0]  w_wr_head;
    logic               w_wr_empty;
    logic               w_wr_full;

    logic [c_CNT_W-1:0] r_fill_cnt;
    logic [c_CNT_W-1:0] r_evict_cnt;
    logic               w_fill_ready;
    logic               w_fill_beat;
    logic               w_fill_done;
    logic               w_evict_beat;
    logic               w_evict_done;

    // ------------------------------------------------------------------
    // Unpack the flat per-cache buses and decide eligibility: a cache may
    // only be granted if the order FIFO for its packet type has room.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < num_caches_p; i++) begin : g_unpack
        assign w_pkt[i]   = dma_pkt_i[i*dma_pkt_width_p +: dma_pkt_width_p];
        assign w_evict[i] = dma_data_i[i*data_width_p +: data_width_p];
        assign w_elig[i]  = dma_pkt_v_i[i]
                          & (w_pkt[i][c_WNR] ? ~w_wr_full : ~w_rd_full);
    end

    // Round-robin: first eligible cache at or after the pointer. Scanning
    // from the far end lets the closest candidate win the last assignment.
    always_comb begin
        logic [c_ID_W-1:0] v_idx;
        w_any = 1'b0;
        w_sel = '0;
        v_idx = '0;
        for (int k = num_caches_p - 1; k >= 0; k--) begin
            v_idx = c_ID_W'((int'(r_rr_ptr) + k) % num_caches_p);
            if (w_elig[v_idx]) begin
                w_any = 1'b1;
                w_sel = v_idx;
            end
        end
    end

    assign w_accept  = w_any & mem_pkt_yumi_i;
    assign w_sel_wnr = w_pkt[w_sel][c_WNR];

    assign mem_pkt_o   = w_pkt[w_sel];
    assign mem_pkt_v_o = reset_n_i & w_any;

    always_comb begin
        dma_pkt_yumi_o = '0;
        if (reset_n_i && w_accept) begin
            dma_pkt_yumi_o[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_sel == c_LAST_ID) ? '0 : w_sel + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-burst order tracking
    // ------------------------------------------------------------------
    bsg_manycore_vcache_dma_order_fifo #(
        .ELS      (order_fifo_els_p),
        .ID_WIDTH (c_ID_W)
    ) u_read_fifo (
        .i_clk   (clk_i),
        .i_rst_n (reset_n_i),
        .i_push  (w_accept & ~w_sel_wnr),
        .i_id    (w_sel),
        .i_pop   (w_fill_done),
        .o_head  (w_rd_head),
        .o_empty (w_rd_empty),
        .o_full  (w_rd_full)
    );

    bsg_manycore_vcache_dma_order_fifo #(
        .ELS      (order_fifo_els_p),
        .ID_WIDTH (c_ID_W)
    ) u_write_fifo (
        .i_clk   (clk_i),
        .i_rst_n (reset_n_i),
        .i_push  (w_accept & w_sel_wnr),
        .i_id    (w_sel),
        .i_pop   (w_evict_done),
        .o_head  (w_wr_head),
        .o_empty (w_wr_empty),
        .o_full  (w_wr_full)
    );

    // ------------------------------------------------------------------
    // Fill path: downstream data goes to the oldest outstanding reader.
    // With no read outstanding, ready stays low so stray data is not acked.
    // ------------------------------------------------------------------
    assign dma_data_o   = mem_data_i;
    assign w_fill_ready = ~w_rd_empty & dma_data_ready_i[w_rd_head];
    assign w_fill_beat  = mem_data_v_i & w_fill_ready;
    assign w_fill_done  = w_fill_beat & (r_fill_cnt == c_LAST_BEAT);

    assign mem_data_ready_o = reset_n_i & w_fill_ready;

    always_comb begin
        dma_data_v_o = '0;
        dma_data_v_o[w_rd_head] = reset_n_i & mem_data_v_i & ~w_rd_empty;
    end

    // ------------------------------------------------------------------
    // Evict path: data is taken from the oldest outstanding writer.
    // ------------------------------------------------------------------
    assign mem_data_o   = w_evict[w_wr_head];
    assign mem_data_v_o = reset_n_i & ~w_wr_empty & dma_data_v_i[w_wr_head];
    assign w_evict_beat = mem_data_yumi_i & ~w_wr_empty;
    assign w_evict_done = w_evict_beat & (r_evict_cnt == c_LAST_BEAT);

    always_comb begin
        dma_data_yumi_o = '0;
        dma_data_yumi_o[w_wr_head] = reset_n_i & mem_data_yumi_i;
    end

    // Beat counters for the burst currently at each FIFO head.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fill_cnt  <= '0;
            r_evict_cnt <= '0;
        end else begin
            if (w_fill_beat) begin
                r_fill_cnt <= w_fill_done ? '0 : r_fill_cnt + 1'b1;
            end
            if (w_evict_beat) begin
                r_evict_cnt <= w_evict_done ? '0 : r_evict_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_vcache_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_vcache_dma_arbiter
// Purpose  : Directed scoreboard bench for the vcache DMA arbiter
//            (4 caches, 8-word bursts, 4-deep order FIFOs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_manycore_vcache_dma_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int PW = 8;
    localparam int B  = 8;
    localparam int F  = 4;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [N*PW-1:0] dma_pkt_i;
    logic [N-1:0]    dma_pkt_v_i;
    logic [N-1:0]    dma_pkt_yumi_o;
    logic [DW-1:0]   dma_data_o;
    logic [N-1:0]    dma_data_v_o;
    logic [N-1:0]    dma_data_ready_i;
    logic [N*DW-1:0] dma_data_i;
    logic [N-1:0]    dma_data_v_i;
    logic [N-1:0]    dma_data_yumi_o;
    logic [PW-1:0]   mem_pkt_o;
    logic            mem_pkt_v_o;
    logic            mem_pkt_yumi_i;
    logic [DW-1:0]   mem_data_i;
    logic            mem_data_v_i;
    logic            mem_data_ready_o;
    logic [DW-1:0]   mem_data_o;
    logic            mem_data_v_o;
    logic            mem_data_yumi_i;

    always #5 clk_i = ~clk_i;

    bsg_manycore_vcache_dma_arbiter #(
        .num_caches_p          (N),
        .data_width_p          (DW),
        .dma_pkt_width_p       (PW),
        .block_size_in_words_p (B),
        .order_fifo_els_p      (F)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .dma_pkt_i        (dma_pkt_i),
        .dma_pkt_v_i      (dma_pkt_v_i),
        .dma_pkt_yumi_o   (dma_pkt_yumi_o),
        .dma_data_o       (dma_data_o),
        .dma_data_v_o     (dma_data_v_o),
        .dma_data_ready_i (dma_data_ready_i),
        .dma_data_i       (dma_data_i),
        .dma_data_v_i     (dma_data_v_i),
        .dma_data_yumi_o  (dma_data_yumi_o),
        .mem_pkt_o        (mem_pkt_o),
        .mem_pkt_v_o      (mem_pkt_v_o),
        .mem_pkt_yumi_i   (mem_pkt_yumi_i),
        .mem_data_i       (mem_data_i),
        .mem_data_v_i     (mem_data_v_i),
        .mem_data_ready_o (mem_data_ready_o),
        .mem_data_o       (mem_data_o),
        .mem_data_v_o     (mem_data_v_o),
        .mem_data_yumi_i  (mem_data_yumi_i)
    );

    typedef struct { int id; logic [PW-1:0] pkt; } pkt_e_t;
    typedef struct { int id; logic [DW-1:0] d;   } dat_e_t;

    pkt_e_t q_pkt  [$];
    dat_e_t q_fill [$];
    dat_e_t q_ev   [$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   fill_idx = 0;
    int   ev_idx [N];
    logic ev_mode  = 1'b0;
    logic ev_tgl   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: every handshake seen on a shared channel is matched against
    // the head of the corresponding expectation queue.
    // ------------------------------------------------------------------
    pkt_e_t mon_p;
    dat_e_t mon_d;
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (mem_pkt_v_o && mem_pkt_yumi_i) begin
                if (q_pkt.size() == 0) chk("pkt_unexpected", 32'd1, 32'd0);
                else begin
                    mon_p = q_pkt.pop_front();
                    chk("pkt_data", 32'(mem_pkt_o), 32'(mon_p.pkt));
                    chk("pkt_yumi", 32'(dma_pkt_yumi_o), 32'(1) << mon_p.id);
                end
            end
            if (mem_data_v_i && mem_data_ready_o) begin
                if (q_fill.size() == 0) chk("fill_unexpected", 32'd1, 32'd0);
                else begin
                    mon_d = q_fill.pop_front();
                    chk("fill_v",    32'(dma_data_v_o), 32'(1) << mon_d.id);
                    chk("fill_data", 32'(dma_data_o),   32'(mon_d.d));
                end
            end
            if (mem_data_v_o && mem_data_yumi_i) begin
                if (q_ev.size() == 0) chk("ev_unexpected", 32'd1, 32'd0);
                else begin
                    mon_d = q_ev.pop_front();
                    chk("ev_data", 32'(mem_data_o),      32'(mon_d.d));
                    chk("ev_yumi", 32'(dma_data_yumi_o), 32'(1) << mon_d.id);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_pkt(input int c, input logic wnr, input logic [6:0] addr);
        dma_pkt_i[c*PW +: PW] = {wnr, addr};
        dma_pkt_v_i[c] = 1'b1;
    endtask

    task automatic exp_pkt(input int c, input logic wnr, input logic [6:0] addr);
        pkt_e_t e;
        e.id = c; e.pkt = {wnr, addr};
        q_pkt.push_back(e);
    endtask

    task automatic exp_fill(input int c);
        dat_e_t e;
        for (int b = 0; b < B; b++) begin
            e.id = c;
            e.d  = DW'(32'hA000 + fill_idx + q_fill.size());
            q_fill.push_back(e);
        end
    endtask

    task automatic exp_evict(input int c);
        dat_e_t e;
        for (int b = 0; b < B; b++) begin
            e.id = c;
            e.d  = DW'(32'hE000 + c*256 + b);
            q_ev.push_back(e);
        end
    endtask

    task automatic set_ev_data(input int c);
        dma_data_i[c*DW +: DW] = DW'(32'hE000 + c*256 + ev_idx[c]);
    endtask

    // One clock: observe handshakes, then advance the cache/memory models.
    task automatic cycle();
        logic [N-1:0] pk_hs;
        logic         f_hs;
        logic [N-1:0] ev_hs;
        @(negedge clk_i);
        pk_hs = dma_pkt_yumi_o;
        f_hs  = mem_data_v_i & mem_data_ready_o;
        ev_hs = dma_data_yumi_o & {N{mem_data_v_o & mem_data_yumi_i}};
        @(posedge clk_i);
        #1;
        dma_pkt_v_i = dma_pkt_v_i & ~pk_hs;
        if (f_hs) fill_idx++;
        mem_data_i = DW'(32'hA000 + fill_idx);
        for (int c = 0; c < N; c++) begin
            if (ev_hs[c]) begin
                ev_idx[c]++;
                set_ev_data(c);
                if (ev_idx[c] == B) dma_data_v_i[c] = 1'b0;
            end
        end
        #1;
        if (ev_mode) begin
            ev_tgl = ~ev_tgl;
            mem_data_yumi_i = ev_tgl & mem_data_v_o;
        end else begin
            mem_data_yumi_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        logic gap_done;
        for (int c = 0; c < N; c++) ev_idx[c] = 0;

        // ---------------- reset state, with all inputs asserted ----------
        reset_n_i        = 1'b0;
        dma_pkt_i        = '0;
        dma_pkt_v_i      = '1;
        dma_data_ready_i = '1;
        dma_data_i       = '0;
        dma_data_v_i     = '1;
        mem_pkt_yumi_i   = 1'b1;
        mem_data_i       = '0;
        mem_data_v_i     = 1'b1;
        mem_data_yumi_i  = 1'b1;
        #12;
        chk("rst_mem_pkt_v",    32'(mem_pkt_v_o),      32'd0);
        chk("rst_pkt_yumi",     32'(dma_pkt_yumi_o),   32'd0);
        chk("rst_dma_data_v",   32'(dma_data_v_o),     32'd0);
        chk("rst_mem_ready",    32'(mem_data_ready_o), 32'd0);
        chk("rst_mem_data_v",   32'(mem_data_v_o),     32'd0);
        chk("rst_ev_yumi",      32'(dma_data_yumi_o),  32'd0);
        dma_pkt_v_i     = '0;
        dma_data_v_i    = '0;
        mem_pkt_yumi_i  = 1'b0;
        mem_data_v_i    = 1'b0;
        mem_data_yumi_i = 1'b0;
        mem_data_i      = DW'(32'hA000);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // ---------------- four reads at once, round-robin grant --------
        for (int c = 0; c < N; c++) set_pkt(c, 1'b0, 7'(16 + c));
        #1;
        chk("hold_pkt_v",    32'(mem_pkt_v_o),    32'd1);
        chk("hold_pkt_data", 32'(mem_pkt_o),      32'h10);
        chk("hold_pkt_yumi", 32'(dma_pkt_yumi_o), 32'd0);
        cycle();
        mem_pkt_yumi_i = 1'b1;
        for (int c = 0; c < N; c++) exp_pkt(c, 1'b0, 7'(16 + c));
        repeat (N) cycle();
        chk("grants_done", 32'(mem_pkt_v_o), 32'd0);

        // ---------------- fill bursts 0..3, ready gap on cache 1 -------
        for (int c = 0; c < N; c++) exp_fill(c);
        mem_data_v_i = 1'b1;
        gap_done = 1'b0;
        for (int k = 0; k < 200 && fill_idx < 32; k++) begin
            if (fill_idx == 10 && !gap_done) begin
                dma_data_ready_i[1] = 1'b0;
                #1;
                chk("gap_ready", 32'(mem_data_ready_o), 32'd0);
                chk("gap_fill_v", 32'(dma_data_v_o), 32'b0010);
                cycle();
                cycle();
                dma_data_ready_i[1] = 1'b1;
                gap_done = 1'b1;
            end else begin
                cycle();
            end
        end
        chk("fill_beats", 32'(fill_idx), 32'd32);
        #1;
        chk("orphan_ready",  32'(mem_data_ready_o), 32'd0);
        chk("orphan_fill_v", 32'(dma_data_v_o),     32'd0);
        mem_data_v_i = 1'b0;

        // ---------------- read FIFO full: 5th read stalls, write goes ---
        for (int c = 0; c < N; c++) begin
            set_pkt(c, 1'b0, 7'(16 + c));
            exp_pkt(c, 1'b0, 7'(16 + c));
        end
        repeat (N) cycle();
        set_pkt(0, 1'b0, 7'h55);
        cycle();
        chk("full_stall_v",    32'(mem_pkt_v_o),    32'd0);
        chk("full_stall_yumi", 32'(dma_pkt_yumi_o), 32'd0);
        set_pkt(2, 1'b1, 7'h22);
        set_pkt(3, 1'b1, 7'h33);
        exp_pkt(2, 1'b1, 7'h22);
        exp_pkt(3, 1'b1, 7'h33);
        for (int k = 0; k < 20 && dma_pkt_v_i[3:2] != 2'b00; k++) cycle();
        chk("writes_granted", 32'(dma_pkt_v_i[3:2]), 32'd0);
        #1;
        chk("read_still_blocked", 32'(mem_pkt_v_o), 32'd0);
        exp_pkt(0, 1'b0, 7'h55);

        // ---------------- concurrent fills and toggling evicts ---------
        exp_fill(0); exp_fill(1); exp_fill(2); exp_fill(3); exp_fill(0);
        exp_evict(2); exp_evict(3);
        for (int c = 0; c < N; c++) set_ev_data(c);
        dma_data_v_i = 4'b1100;
        ev_mode      = 1'b1;
        mem_data_v_i = 1'b1;
        for (int k = 0; k < 400 && !(fill_idx == 72 && ev_idx[2] == B && ev_idx[3] == B); k++)
            cycle();
        chk("conc_fill_beats", 32'(fill_idx),  32'd72);
        chk("ev2_beats",       32'(ev_idx[2]), 32'd8);
        chk("ev3_beats",       32'(ev_idx[3]), 32'd8);
        ev_mode = 1'b0;
        mem_data_yumi_i = 1'b0;
        #1;
        chk("ev_drained",     32'(mem_data_v_o),     32'd0);
        chk("fill_drained",   32'(mem_data_ready_o), 32'd0);
        chk("q_pkt_empty",    32'(q_pkt.size()),     32'd0);
        chk("q_fill_empty",   32'(q_fill.size()),    32'd0);
        chk("q_ev_empty",     32'(q_ev.size()),      32'd0);
        mem_data_v_i = 1'b0;

        // ---------------- reset pulse in the middle of a fill ----------
        set_pkt(1, 1'b0, 7'h61);
        exp_pkt(1, 1'b0, 7'h61);
        cycle();
        exp_fill(1);
        mem_data_v_i = 1'b1;
        start = fill_idx;
        for (int k = 0; k < 20 && fill_idx < start + 3; k++) cycle();
        chk("pre_rst_beats", 32'(fill_idx - start), 32'd3);
        #2;
        reset_n_i = 1'b0;
        set_pkt(3, 1'b0, 7'h70);
        #1;
        chk("midrst_fill_v",   32'(dma_data_v_o),     32'd0);
        chk("midrst_ready",    32'(mem_data_ready_o), 32'd0);
        chk("midrst_pkt_v",    32'(mem_pkt_v_o),      32'd0);
        chk("midrst_pkt_yumi", 32'(dma_pkt_yumi_o),   32'd0);
        q_fill.delete();
        dma_pkt_v_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_ready",  32'(mem_data_ready_o), 32'd0);
        chk("post_rst_ev_v",   32'(mem_data_v_o),     32'd0);
        set_pkt(2, 1'b0, 7'h62);
        exp_pkt(2, 1'b0, 7'h62);
        exp_fill(2);
        start = fill_idx;
        for (int k = 0; k < 60 && fill_idx < start + B; k++) cycle();
        chk("post_rst_burst", 32'(fill_idx - start), 32'd8);
        #1;
        chk("post_rst_drain", 32'(mem_data_ready_o), 32'd0);
        chk("post_rst_q",     32'(q_fill.size()),    32'd0);
        mem_data_v_i = 1'b0;

        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
